// File: rtl/ref_mem_ctrl_param_if.sv
// Bus between the search engine (master) and the reference-RAM controller (slave).
// The controller drives the bank write strobes and the read port of the reference RAM.
interface ref_mem_ctrl_param_if #(
    parameter int NUM_BANKS = 32,
    parameter int AW        = 7,
    parameter int SELW      = 4
);
    logic                    begin_prepare;
    logic                    data_valid;
    logic                    rd_req;
    logic [AW-1:0]           rd_line_base;
    logic [SELW-1:0]         rd_col;
    logic                    shift_req;
    logic [NUM_BANKS-1:0]    Bank_sel;
    logic [AW*NUM_BANKS-1:0] write_address_all;
    logic [AW-1:0]           rd_address;
    logic                    rd8R_en;
    logic [SELW-1:0]         rdR_sel;
    logic                    ready;
    logic                    busy;

    modport master (
        output begin_prepare, data_valid, rd_req, rd_line_base, rd_col, shift_req,
        input  Bank_sel, write_address_all, rd_address, rd8R_en, rdR_sel, ready, busy
    );

    modport slave (
        input  begin_prepare, data_valid, rd_req, rd_line_base, rd_col, shift_req,
        output Bank_sel, write_address_all, rd_address, rd8R_en, rdR_sel, ready, busy
    );
endinterface

// File: rtl/ref_mem_ctrl_param.sv
// Reference-window memory controller: preloads all banks group by group, primes the
// read pipe, then serves read bursts and refills the oldest group on request.
module ref_mem_ctrl_param #(
    parameter int NUM_BANKS = 32,
    parameter int GRP       = 4,
    parameter int LINES     = 96,
    parameter int AW        = 7,
    parameter int RD_LINES  = 4,
    parameter int SELW      = 4
) (
    input logic                 clk,
    input logic                 rst,
    ref_mem_ctrl_param_if.slave bus
);
    localparam int NUM_GRP = NUM_BANKS / GRP;
    localparam int GW      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int KW      = (RD_LINES > 1) ? $clog2(RD_LINES) : 1;
    localparam logic [AW-1:0] LAST_LINE = AW'(LINES - 1);
    localparam logic [GW-1:0] LAST_GRP  = GW'(NUM_GRP - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(RD_LINES - 1);

    typedef enum logic [2:0] {IDLE, PRELOAD, PRIME, SEARCH, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           line_cnt_q, line_cnt_d;
    logic [GW-1:0]           grp_cnt_q, grp_cnt_d;
    logic [GW-1:0]           oldest_grp_q, oldest_grp_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    burst_q, burst_d;
    logic                    pending_q, pending_d;
    logic [NUM_BANKS-1:0]    bank_sel_q, bank_sel_d;
    logic [AW*NUM_BANKS-1:0] waddr_q, waddr_d;
    logic [AW-1:0]           rd_address_q, rd_address_d;
    logic                    rd8r_en_q, rd8r_en_d;
    logic [SELW-1:0]         rdr_sel_q, rdr_sel_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic [GW-1:0]           wr_grp;
    logic [AW-1:0]           next_rd;
    logic [31:0]             base_ext;
    logic [AW-1:0]           base_mod;

    // Every output is computed here for the following cycle; k_q counts the
    // position inside a prime sequence or read burst.
    always_comb begin
        wr_grp       = (state_q == REFILL) ? oldest_grp_q : grp_cnt_q;
        next_rd      = (rd_address_q == LAST_LINE) ? '0 : rd_address_q + 1'b1;
        base_ext     = 32'(bus.rd_line_base);
        base_mod     = AW'(base_ext % 32'(LINES));

        state_d      = state_q;
        line_cnt_d   = line_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        oldest_grp_d = oldest_grp_q;
        k_d          = k_q;
        burst_d      = 1'b0;
        pending_d    = pending_q;
        bank_sel_d   = '0;
        waddr_d      = waddr_q;
        rd_address_d = rd_address_q;
        rd8r_en_d    = 1'b1;
        rdr_sel_d    = rdr_sel_q;
        ready_d      = 1'b0;
        busy_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.begin_prepare) begin
                    state_d      = PRELOAD;
                    line_cnt_d   = '0;
                    grp_cnt_d    = '0;
                    oldest_grp_d = '0;
                    busy_d       = 1'b1;
                end
            end
            PRELOAD, REFILL: begin
                busy_d = 1'b1;
                if (state_q == REFILL) begin
                    pending_d = pending_q | bus.shift_req;
                end
                if (bus.data_valid) begin
                    bank_sel_d = NUM_BANKS'({GRP{1'b1}}) << (GRP * int'(wr_grp));
                    waddr_d    = {NUM_BANKS{line_cnt_q}};
                    if (line_cnt_q == LAST_LINE) begin
                        line_cnt_d = '0;
                        if (state_q == REFILL) begin
                            oldest_grp_d = (oldest_grp_q == LAST_GRP) ? '0 : oldest_grp_q + 1'b1;
                            state_d      = SEARCH;
                        end else if (grp_cnt_q == LAST_GRP) begin
                            grp_cnt_d = '0;
                            k_d       = '0;
                            state_d   = PRIME;
                        end else begin
                            grp_cnt_d = grp_cnt_q + 1'b1;
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
            end
            PRIME: begin
                busy_d       = 1'b1;
                rd8r_en_d    = 1'b0;
                rdr_sel_d    = '0;
                rd_address_d = AW'(k_q);
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = SEARCH;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            SEARCH: begin
                ready_d   = 1'b1;
                pending_d = pending_q | bus.shift_req;
                // A read wins over a pending refill; the refill waits for the burst to drain.
                if (burst_q && (k_q != LAST_K)) begin
                    burst_d      = 1'b1;
                    k_d          = k_q + 1'b1;
                    rd_address_d = next_rd;
                    rd8r_en_d    = 1'b0;
                    busy_d       = 1'b1;
                end else if (!burst_q && bus.rd_req) begin
                    burst_d      = 1'b1;
                    k_d          = '0;
                    rd_address_d = base_mod;
                    rdr_sel_d    = bus.rd_col;
                    rd8r_en_d    = 1'b0;
                    busy_d       = 1'b1;
                end else if (!burst_q && pending_q) begin
                    pending_d  = bus.shift_req;
                    line_cnt_d = '0;
                    state_d    = REFILL;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_cnt_q   <= '0;
            grp_cnt_q    <= '0;
            oldest_grp_q <= '0;
            k_q          <= '0;
            burst_q      <= 1'b0;
            pending_q    <= 1'b0;
            bank_sel_q   <= '0;
            waddr_q      <= '0;
            rd_address_q <= '0;
            rd8r_en_q    <= 1'b1;
            rdr_sel_q    <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            oldest_grp_q <= oldest_grp_d;
            k_q          <= k_d;
            burst_q      <= burst_d;
            pending_q    <= pending_d;
            bank_sel_q   <= bank_sel_d;
            waddr_q      <= waddr_d;
            rd_address_q <= rd_address_d;
            rd8r_en_q    <= rd8r_en_d;
            rdr_sel_q    <= rdr_sel_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.Bank_sel          = bank_sel_q;
    assign bus.write_address_all = waddr_q;
    assign bus.rd_address        = rd_address_q;
    assign bus.rd8R_en           = rd8r_en_q;
    assign bus.rdR_sel           = rdr_sel_q;
    assign bus.ready             = ready_q;
    assign bus.busy              = busy_q;
endmodule

// File: doc/ref_mem_ctrl_param.md
REF_MEM_CTRL_PARAM -- requirements
Module: ref_mem_ctrl_param

Interface
REQ-001 SHALL have parameters, one per line:
  NUM_BANKS, 32, number of reference RAM banks
  GRP, 4, banks per preload/refill group (NUM_BANKS divisible by GRP)
  LINES, 96, lines per bank
  AW, 7, bank address width (2^AW >= LINES)
  RD_LINES, 4, lines read per search-point burst
  SELW, 4, rdR_sel width
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock; all logic on rising edge
  rst  in  1  synchronous, active-high reset
  begin_prepare  in  1  start full preload; sampled in IDLE only
  data_valid  in  1  external line data present this cycle
  rd_req  in  1  request a read burst
  rd_line_base  in  AW  first line of burst
  rd_col  in  SELW  column select for burst
  shift_req  in  1  request refill of the oldest group
  Bank_sel  out  NUM_BANKS  per-bank write enable
  write_address_all  out  AW*NUM_BANKS  per-bank write address, bank i at [AW*i +: AW]
  rd_address  out  AW  common read address
  rd8R_en  out  1  read enable, active-low
  rdR_sel  out  SELW  read column select
  ready  out  1  window valid, SEARCH accepts requests
  busy  out  1  high in PRELOAD, PRIME, REFILL or during a read burst

Function
REQ-003 SHALL implement states IDLE, PRELOAD, PRIME, SEARCH, REFILL; all outputs registered.
REQ-004 IDLE -> PRELOAD when begin_prepare=1; begin_prepare ignored in all other states.
REQ-005 PRELOAD: counters line_cnt (0..LINES-1) and grp_cnt (0..NUM_BANKS/GRP-1), both 0 on entry.
REQ-006 PRELOAD, data_valid=1: next cycle Bank_sel = GRP ones at bits [GRP*grp_cnt +: GRP], write_address_all = line_cnt replicated NUM_BANKS times; line_cnt increments.
REQ-007 PRELOAD, data_valid=0: next cycle Bank_sel = 0, counters hold (stall, no lost lines).
REQ-008 line_cnt wraps LINES-1 -> 0 with grp_cnt increment; write of last line of last group -> PRIME.
REQ-009 PRIME: RD_LINES cycles, rd_address = 0,1,..,RD_LINES-1, rd8R_en=0, rdR_sel=0, Bank_sel=0; then SEARCH.
REQ-010 SEARCH: ready=1; rd8R_en=1 and Bank_sel=0 when no burst active.
REQ-011 rd_req accepted in SEARCH when no burst active; burst starts the following cycle: RD_LINES cycles, rd_address = (rd_line_base + k) mod LINES, k = 0..RD_LINES-1, rd8R_en=0, rdR_sel = rd_col captured at acceptance.
REQ-012 rd_req during active burst or outside SEARCH SHALL be ignored (no queueing).
REQ-013 shift_req in SEARCH latches a pending flag; when no burst is active and pending=1, clear pending and enter REFILL.
REQ-014 rd_req and pending shift on the same idle SEARCH cycle: read accepted first; refill starts after burst completes.
REQ-015 REFILL: ready=0; writes group oldest_grp exactly as REQ-006/007 with line_cnt 0..LINES-1; after last line, oldest_grp = (oldest_grp+1) mod (NUM_BANKS/GRP), return to SEARCH.
REQ-016 oldest_grp SHALL be 0 after PRELOAD; shift_req during REFILL latches pending for a subsequent refill.
REQ-017 Address arithmetic SHALL be AW bits, modulo LINES, never emitting an address >= LINES.

Reset
REQ-018 rst=1 at any clock edge, including mid-PRELOAD/REFILL/burst: state IDLE; Bank_sel=0, write_address_all=0, rd_address=0, rd8R_en=1, rdR_sel=0, ready=0, busy=0; counters, oldest_grp, pending flag cleared.
REQ-019 First begin_prepare after reset SHALL restart preload from group 0 line 0.

Verification
REQ-020 Default params, begin_prepare pulse, data_valid=1 always -> 768 writes, group g active cycles 96g..96g+95, then rd_address 0..3 with rd8R_en=0, ready=1 next cycle.
REQ-021 data_valid low 1 of every 3 cycles during PRELOAD -> Bank_sel=0 on stall cycles, no line skipped or repeated, still 768 writes total.
REQ-022 SEARCH, rd_req with rd_line_base=94, rd_col=5 -> rd_address 94,95,0,1, rdR_sel=5, rd8R_en=0 for exactly 4 cycles.
REQ-023 rd_req and shift_req same cycle -> 4-cycle read burst, then REFILL of banks 0..3 (96 writes), then second shift refills banks 4..7; ninth shift wraps to banks 0..3.
REQ-024 rst asserted at PRELOAD write 300 -> next cycle all outputs at reset values; new begin_prepare restarts at group 0 line 0.
REQ-025 NUM_BANKS=16, GRP=2, LINES=64, AW=6 -> 8 groups x 64 lines preload, bit positions and addresses scale accordingly.
